// File: rtl/memory_arbiter_rr.sv
// rtl/memory_arbiter_rr.sv - round-robin arbiter sharing one RAM among per-core I/D channels
module memory_arbiter_rr #(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [CPUS-1:0]    iREN,
  input  logic [CPUS-1:0]    dREN,
  input  logic [CPUS-1:0]    dWEN,
  input  logic [CPUS*AW-1:0] iaddr,
  input  logic [CPUS*AW-1:0] daddr,
  input  logic [CPUS*DW-1:0] dstore,
  output logic [CPUS-1:0]    iwait,
  output logic [CPUS-1:0]    dwait,
  output logic [CPUS*DW-1:0] iload,
  output logic [CPUS*DW-1:0] dload,
  output logic               ramREN,
  output logic               ramWEN,
  output logic [AW-1:0]      ramaddr,
  output logic [DW-1:0]      ramstore,
  input  logic [DW-1:0]      ramload,
  input  logic [1:0]         ramstate
);

  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] gcore_q, gcore_d;
  logic          gtype_q, gtype_d;   // 1 = data channel, 0 = instruction channel

  logic [CPUS-1:0] dreq;
  logic [CPUS-1:0] ireq;
  logic            scan_hit;
  logic [PW-1:0]   scan_core;
  logic            scan_data;
  logic            grant_live;
  logic            grant_write;
  logic [AW-1:0]   g_iaddr;
  logic [AW-1:0]   g_daddr;
  logic [DW-1:0]   g_dstore;

  // A write wins when a core raises dREN and dWEN together
  assign dreq = dREN | dWEN;
  assign ireq = iREN;

  // Read data is simply broadcast; only the core whose wait drops consumes it
  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  // Granted core's request, live-sampled so an abort is seen the same cycle
  assign grant_live  = gtype_q ? dreq[gcore_q] : ireq[gcore_q];
  assign grant_write = dWEN[gcore_q];
  assign g_iaddr     = iaddr[int'(gcore_q)*AW +: AW];
  assign g_daddr     = daddr[int'(gcore_q)*AW +: AW];
  assign g_dstore    = dstore[int'(gcore_q)*DW +: DW];

  // Scan cores from rr_ptr upward with explicit wrap; first requester wins, data over instruction
  always_comb begin
    int            idx;
    logic [PW-1:0] cidx;
    idx       = 0;
    cidx      = '0;
    scan_hit  = 1'b0;
    scan_core = '0;
    scan_data = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= CPUS) begin
        idx = idx - CPUS;
      end
      cidx = idx[PW-1:0];
      if (!scan_hit && (dreq[cidx] || ireq[cidx])) begin
        scan_hit  = 1'b1;
        scan_core = cidx;
        scan_data = dreq[cidx];
      end
    end
  end

  // Next-state, RAM drive and wait generation
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gcore_d  = gcore_q;
    gtype_d  = gtype_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    case (state_q)
      ST_IDLE: begin
        if (scan_hit) begin
          gcore_d = scan_core;
          gtype_d = scan_data;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!grant_live) begin
          // Requester walked away: release the RAM, keep rr_ptr so it is rescanned first
          state_d = ST_IDLE;
        end else begin
          if (gtype_q) begin
            ramaddr = g_daddr;
            if (grant_write) begin
              ramWEN   = 1'b1;
              ramstore = g_dstore;
            end else begin
              ramREN = 1'b1;
            end
          end else begin
            ramREN  = 1'b1;
            ramaddr = g_iaddr;
          end
          // FREE, BUSY and ERROR all hold the grant; only ACCESS completes it
          if (ramstate == RAM_ACCESS) begin
            if (gtype_q) begin
              dwait[gcore_q] = 1'b0;
            end else begin
              iwait[gcore_q] = 1'b0;
            end
            state_d  = ST_IDLE;
            rr_ptr_d = (int'(gcore_q) == CPUS - 1) ? '0 : gcore_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and grant registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gcore_q  <= '0;
      gtype_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gcore_q  <= gcore_d;
      gtype_q  <= gtype_d;
    end
  end

endmodule

// File: doc/memory_arbiter_rr.md
Name: memory_arbiter_rr

Overview:
- Multi-core RAM arbiter. Shares one single-ported RAM among CPUS cores, each with an instruction channel and a data channel.
- Round-robin across cores; within a core, data has priority over instruction.
- Each grant is registered and held until the RAM completes the access.
- Sits between the per-core cache_control_if ports and the RAM model; a coherence layer is added later above it.

Parameters:
- CPUS, 2, number of cores (1..8).
- AW, 32, address width.
- DW, 32, data word width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  CPUS  instruction read request, per core.
- dREN  in  CPUS  data read request, per core.
- dWEN  in  CPUS  data write request, per core.
- iaddr  in  CPUS*AW  instruction addresses; core k at bits [k*AW +: AW].
- daddr  in  CPUS*AW  data addresses, packed the same way.
- dstore  in  CPUS*DW  write data, packed the same way.
- iwait  out  CPUS  instruction stall; low = access complete this cycle.
- dwait  out  CPUS  data stall; low = access complete this cycle.
- iload  out  CPUS*DW  instruction read data; ramload broadcast to every core.
- dload  out  CPUS*DW  data read data; ramload broadcast to every core.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset, asynchronous on nRST low:
  - State = IDLE, rr_ptr = 0, grant registers cleared.
  - All iwait/dwait = 1; ramREN = ramWEN = 0; ramaddr = 0; ramstore = 0.
- Request per core k:
  - dreq[k] = dREN[k] | dWEN[k].
  - ireq[k] = iREN[k].
  - If dREN and dWEN are both high, the access is a write.
- IDLE state:
  - RAM enables = 0; all waits = 1.
  - If any request is present, scan cores starting at rr_ptr, upward with wrap modulo CPUS.
  - The first core with dreq or ireq wins. Latch gcore and gtype: data if dreq, otherwise instruction.
  - Next state = GRANT. With no request, stay in IDLE.
- GRANT state, granted source only:
  - Data read: ramREN = 1, ramaddr = daddr[gcore].
  - Data write: ramWEN = 1, ramaddr = daddr[gcore], ramstore = dstore[gcore].
  - Instruction: ramREN = 1, ramaddr = iaddr[gcore].
  - The read/write mode is re-evaluated each cycle from the live dWEN.
  - ramstate == ACCESS: drop the granted wait to 0 for exactly this cycle. Next state = IDLE; rr_ptr = (gcore+1) mod CPUS.
  - ramstate FREE or BUSY: hold the grant; wait stays 1.
  - ramstate ERROR: treat as BUSY (wait stays 1, grant held).
  - Abort: if the granted request drops before ACCESS, deassert RAM enables that same cycle and go to IDLE next. rr_ptr is not advanced and no wait pulse is produced.
- Latency:
  - Request sampled at edge N; RAM driven from cycle N+1.
  - Fastest completion is wait low in cycle N+1.
  - One IDLE bubble cycle separates back-to-back grants.
- Non-granted sources always see wait = 1. Their RAM inputs are ignored.
- Fairness:
  - A core is served at most once per rotation while others are requesting.
  - A core holding both dreq and ireq is served data first. Its instruction fetch waits for the next rotation that reaches it.
- Widths: rr_ptr and gcore are $clog2(CPUS) bits, minimum 1. Wrap uses explicit compare, valid for non-power-of-2 CPUS.
- CPUS = 1: reduces to data-over-instruction priority with a registered grant.
- Reset asserted mid-GRANT: RAM enables drop immediately and the arbiter returns to IDLE with rr_ptr = 0.

Test Plan:
- Reset and idle: hold nRST low 3 cycles, then no requests for 5 cycles -> all waits = 1, ramREN = ramWEN = 0, ramaddr = 0 throughout.
- Single instruction read: core0 iREN=1, iaddr=0x100, RAM returns ACCESS one cycle after enable with ramload=0xDEADBEEF -> ramaddr=0x100, ramREN=1; iwait[0]=0 for exactly one cycle; iload[0]=0xDEADBEEF.
- Intra-core priority: core1 dWEN=1, daddr=0x200, dstore=0x55, plus iREN=1 -> write granted first (ramWEN=1, ramstore=0x55); instruction granted after one IDLE bubble.
- Round-robin, CPUS=3: all cores hold dREN continuously, RAM completes each access in 2 cycles -> grant order 0,1,2,0,1,2; no core starves.
- Abort: core0 dREN drops while ramstate=BUSY -> ramREN=0 that cycle, no dwait pulse; the next grant goes to the same core's pending iREN, not core1.
- ERROR stall and mid-grant reset: ramstate=ERROR for 10 cycles, then pulse nRST low -> wait stays 1 throughout; outputs return to reset values asynchronously; rr_ptr = 0.
